// File: rtl/byte_stream_packer_pkg.sv
// Shared types and helpers for the byte stream packer.
package byte_stream_packer_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefDataBytes = DefDataWidth / 8;

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/byte_stream_packer_shifter.sv
// Places a MSB-aligned word (len0 + len1) bytes down from the top of a double-width window.
module byte_stream_packer_shifter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [LEN_WIDTH-1:0]    len0_i,
    input  logic [LEN_WIDTH-1:0]    len1_i,
    output logic [2*DATA_WIDTH-1:0] data_o
);

    logic [LEN_WIDTH:0] shift_bytes;

    always_comb begin
        shift_bytes = {1'b0, len0_i} + {1'b0, len1_i};
        data_o      = {data_i, {DATA_WIDTH{1'b0}}} >> {shift_bytes, 3'b000};
    end

endmodule

// File: rtl/byte_stream_packer.sv
// Packs variable-length MSB-aligned byte beats into dense full-width words.
// Optional BYTE_PACKER_CNT_EN adds a running count of emitted bytes (byte_cnt_o).
module byte_stream_packer
    import byte_stream_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [LEN_WIDTH-1:0]  in_len_i,
    input  logic                  in_last_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [LEN_WIDTH-1:0]  out_len_o,
    output logic                  out_last_o
`ifdef BYTE_PACKER_CNT_EN
    ,
    output logic [31:0]           byte_cnt_o
`endif
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned DB = DATA_WIDTH / 8;
    localparam logic [LEN_WIDTH:0]   DbTotal = (LEN_WIDTH + 1)'(DB);
    localparam logic [LEN_WIDTH-1:0] DbLen   = LEN_WIDTH'(DB);

    state_e                state_q, state_d;
    logic [2*W-1:0]        acc_q, acc_d;
    logic [LEN_WIDTH-1:0]  fill_q, fill_d;
    logic                  out_valid_q, out_valid_d;
    logic [W-1:0]          out_data_q, out_data_d;
    logic [LEN_WIDTH-1:0]  out_len_q, out_len_d;
    logic                  out_last_q, out_last_d;

    logic                  slot_free;
    logic                  accept;
    logic [LEN_WIDTH-1:0]  len_c;
    logic [W-1:0]          in_mask;
    logic [W-1:0]          in_masked;
    logic [2*W-1:0]        placed;
    logic [2*W-1:0]        acc_new;
    logic [LEN_WIDTH:0]    total;

    assign slot_free  = !out_valid_q || out_ready_i;
    assign in_ready_o = (state_q == StRun) && slot_free;
    assign accept     = in_valid_i && in_ready_o;
    assign len_c      = LEN_WIDTH'(clamp_len(32'(in_len_i), DB));

    // Bytes past in_len are don't-care upstream; zero them so they cannot pollute acc.
    assign in_mask   = ~({W{1'b1}} >> {len_c, 3'b000});
    assign in_masked = in_data_i & in_mask;

    byte_stream_packer_shifter #(
        .DATA_WIDTH(DATA_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_shifter (
        .data_i(in_masked),
        .len0_i(fill_q),
        .len1_i('0),
        .data_o(placed)
    );

    assign acc_new = acc_q | placed;
    assign total   = {1'b0, fill_q} + {1'b0, len_c};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_len_d   = out_len_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StRun: begin
                if (accept) begin
                    if (total >= DbTotal) begin
                        out_valid_d = 1'b1;
                        out_data_d  = acc_new[2*W-1:W];
                        out_len_d   = DbLen;
                        out_last_d  = in_last_i && (total == DbTotal);
                        acc_d       = acc_new << W;
                        fill_d      = LEN_WIDTH'(total - DbTotal);
                        if (in_last_i && (total > DbTotal)) begin
                            state_d = StFlush;
                        end
                    end else if (!in_last_i) begin
                        acc_d  = acc_new;
                        fill_d = LEN_WIDTH'(total);
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = acc_new[2*W-1:W];
                        out_len_d   = LEN_WIDTH'(total);
                        out_last_d  = 1'b1;
                        acc_d       = '0;
                        fill_d      = '0;
                    end
                end
            end
            StFlush: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q[2*W-1:W];
                    out_len_d   = fill_q;
                    out_last_d  = 1'b1;
                    acc_d       = '0;
                    fill_d      = '0;
                    state_d     = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StRun;
            acc_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_len_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_len_q   <= out_len_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_len_o   = out_len_q;
    assign out_last_o  = out_last_q;

`ifdef BYTE_PACKER_CNT_EN
    logic [31:0] byte_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q <= '0;
        end else if (out_valid_q && out_ready_i) begin
            byte_cnt_q <= byte_cnt_q + 32'(out_len_q);
        end
    end

    assign byte_cnt_o = byte_cnt_q;
`endif

endmodule

// File: tb/tb_byte_stream_packer.sv
// Self-checking bench for byte_stream_packer (DATA_WIDTH=32): vector table, corner sequences,
// and randomized frames checked against a byte-queue reference model.
module tb_byte_stream_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_len;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_len;
    logic        out_last;
`ifdef BYTE_PACKER_CNT_EN
    logic [31:0] byte_cnt;
`endif

    byte_stream_packer #(
        .DATA_WIDTH(32),
        .LEN_WIDTH (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .in_len_i   (in_len),
        .in_last_i  (in_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_len_o  (out_len),
        .out_last_o (out_last)
`ifdef BYTE_PACKER_CNT_EN
        ,
        .byte_cnt_o (byte_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] l,
                         input logic la);
        in_valid = v;
        in_data  = d;
        in_len   = l;
        in_last  = la;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
    endtask

    // Each row: inputs driven this cycle, plus expected in_ready (same cycle) and expected
    // registered outputs, which reflect the rows before it.
    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic [7:0]  len;
        logic        last;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_data;
        logic [7:0]  e_len;
        logic        e_last;
    } vec_t;

    function automatic vec_t mk(input logic vld, input logic [31:0] data, input logic [7:0] len,
                                input logic last, input logic e_rdy, input logic e_ov,
                                input logic [31:0] e_data, input logic [7:0] e_len,
                                input logic e_last);
        vec_t r;
        r.vld = vld; r.data = data; r.len = len; r.last = last;
        r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_data = e_data; r.e_len = e_len; r.e_last = e_last;
        return r;
    endfunction

    typedef struct {
        logic [31:0] data;
        logic [7:0]  len;
        logic        last;
    } beat_t;

    beat_t beats[$];
    beat_t exp_q[$];

    // Reference: a frame is a byte sequence cut into 4-byte words; the tail becomes a
    // partial last word, and a frame whose final beat carries no bytes but ends on a word
    // boundary closes with an empty last word.
    task automatic gen_frame();
        logic [7:0] bytes[$];
        int nb;
        int last_len;
        int n;
        int full;
        int rem;
        beat_t bt;
        beat_t w;
        nb = $urandom_range(1, 5);
        last_len = 0;
        for (int b = 0; b < nb; b++) begin
            int cl;
            bt.data = $urandom;
            bt.len  = 8'($urandom_range(0, 6));
            bt.last = (b == nb - 1);
            beats.push_back(bt);
            cl = (bt.len > 8'd4) ? 4 : int'(bt.len);
            for (int k = 0; k < cl; k++) bytes.push_back(bt.data[31-8*k -: 8]);
            if (bt.last) last_len = cl;
        end
        n    = bytes.size();
        full = n / 4;
        rem  = n % 4;
        for (int i = 0; i < full; i++) begin
            w.data = '0;
            for (int j = 0; j < 4; j++) w.data[31-8*j -: 8] = bytes[4*i+j];
            w.len  = 8'd4;
            w.last = (rem == 0) && (last_len != 0) && (i == full - 1);
            exp_q.push_back(w);
        end
        if (rem != 0 || last_len == 0) begin
            w.data = '0;
            for (int j = 0; j < rem; j++) w.data[31-8*j -: 8] = bytes[4*full+j];
            w.len  = 8'(rem);
            w.last = 1'b1;
            exp_q.push_back(w);
        end
    endtask

    vec_t tbl[18];

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0);

        tbl[0]  = mk(1, 32'hAA123456, 1, 0, 1, 0, 32'h0, 0, 0);
        tbl[1]  = mk(1, 32'hBBFFFFFF, 1, 0, 1, 0, 32'h0, 0, 0);
        tbl[2]  = mk(1, 32'hCC000000, 1, 0, 1, 0, 32'h0, 0, 0);
        tbl[3]  = mk(1, 32'hDD5A5A5A, 1, 0, 1, 0, 32'h0, 0, 0);
        tbl[4]  = mk(1, 32'h112233FF, 3, 0, 1, 1, 32'hAABBCCDD, 4, 0);
        tbl[5]  = mk(1, 32'h445566EE, 3, 1, 1, 0, 32'h0, 0, 0);
        tbl[6]  = mk(0, 32'h0, 0, 0, 0, 1, 32'h11223344, 4, 0);
        tbl[7]  = mk(0, 32'h0, 0, 0, 1, 1, 32'h55660000, 2, 1);
        tbl[8]  = mk(1, 32'h12345678, 0, 1, 1, 0, 32'h0, 0, 0);
        tbl[9]  = mk(1, 32'hCAFEBABE, 9, 1, 1, 1, 32'h00000000, 0, 1);
        tbl[10] = mk(1, 32'h77FFFFFF, 1, 1, 1, 1, 32'hCAFEBABE, 4, 1);
        tbl[11] = mk(1, 32'h01020304, 4, 0, 1, 1, 32'h77000000, 1, 1);
        tbl[12] = mk(1, 32'h05060708, 4, 1, 1, 1, 32'h01020304, 4, 0);
        tbl[13] = mk(1, 32'hA1A2FFFF, 2, 0, 1, 1, 32'h05060708, 4, 1);
        tbl[14] = mk(1, 32'hB1B2B3B4, 4, 0, 1, 0, 32'h0, 0, 0);
        tbl[15] = mk(1, 32'hC1FFFFFF, 1, 1, 1, 1, 32'hA1A2B1B2, 4, 0);
        tbl[16] = mk(0, 32'h0, 0, 0, 1, 1, 32'hB3B4C100, 3, 1);
        tbl[17] = mk(0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 0);

        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_len", 32'(out_len), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        #10;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Vector table
        for (int i = 0; i < 18; i++) begin
            next_cycle();
            drive(tbl[i].vld, tbl[i].data, tbl[i].len, tbl[i].last);
            @(negedge clk);
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_data);
                check($sformatf("tbl%0d_out_len", i), 32'(out_len), 32'(tbl[i].e_len));
                check($sformatf("tbl%0d_out_last", i), 32'(out_last), 32'(tbl[i].e_last));
            end
        end

        // Backpressure: word held for 5 stalled cycles, nothing lost on release
        next_cycle();
        out_ready = 1'b0;
        drive(1'b1, 32'h01020304, 4, 1'b0);
        @(negedge clk);
        check("bp_first_accept", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            drive(1'b1, 32'h05060708, 4, 1'b1);
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", out_data, 32'h01020304);
            check("bp_hold_len", 32'(out_len), 32'd4);
            check("bp_hold_last", 32'(out_last), 32'd0);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        next_cycle();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_data", out_data, 32'h05060708);
        check("bp_second_last", 32'(out_last), 32'd1);
        next_cycle();
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Reset during FLUSH discards residue
        next_cycle();
        drive(1'b1, 32'h11223344, 3, 1'b0);
        next_cycle();
        drive(1'b1, 32'hAABBCCDD, 3, 1'b1);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check("fl_in_flush_ready", 32'(in_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("fl_rst_out_valid", 32'(out_valid), 32'd0);
        check("fl_rst_out_data", out_data, 32'h0);
        #2;
        rst_n = 1'b1;
        next_cycle();
        drive(1'b1, 32'hDEADBEEF, 4, 1'b1);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check("fl_after_valid", 32'(out_valid), 32'd1);
        check("fl_after_data", out_data, 32'hDEADBEEF);
        check("fl_after_len", 32'(out_len), 32'd4);
        check("fl_after_last", 32'(out_last), 32'd1);
        next_cycle();

`ifdef BYTE_PACKER_CNT_EN
        check("cnt_after_deadbeef", byte_cnt, 32'd4);
        do_reset();
        check("cnt_reset", byte_cnt, 32'd0);
        next_cycle();
        drive(1'b1, 32'h00112233, 4, 1'b0);
        next_cycle();
        drive(1'b1, 32'h44556677, 4, 1'b0);
        next_cycle();
        drive(1'b1, 32'h8899FFFF, 2, 1'b1);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) next_cycle();
        check("cnt_10_bytes", byte_cnt, 32'd10);
`endif

        // Randomized frames with random backpressure against the reference model
        do_reset();
        for (int f = 0; f < 60; f++) gen_frame();
        begin
            int idx;
            int cyc;
            logic prev_stall;
            logic [31:0] prev_data;
            logic [7:0]  prev_len;
            logic        prev_last;
            beat_t w;
            idx = 0;
            cyc = 0;
            prev_stall = 1'b0;
            prev_data = '0;
            prev_len = '0;
            prev_last = 1'b0;
            while ((idx < beats.size() || exp_q.size() > 0) && cyc < 20000) begin
                next_cycle();
                cyc++;
                out_ready = ($urandom_range(0, 3) != 0);
                if (idx < beats.size() && $urandom_range(0, 4) != 0) begin
                    drive(1'b1, beats[idx].data, beats[idx].len, beats[idx].last);
                end else begin
                    drive(1'b0, 32'($urandom), 8'($urandom_range(0, 4)), 1'b0);
                end
                @(negedge clk);
                if (prev_stall) begin
                    check("rnd_hold_valid", 32'(out_valid), 32'd1);
                    check("rnd_hold_data", out_data, prev_data);
                    check("rnd_hold_len", 32'(out_len), 32'(prev_len));
                    check("rnd_hold_last", 32'(out_last), 32'(prev_last));
                end
                if (in_valid && in_ready) idx++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rnd_unexpected_word", 32'(out_valid), 32'd0);
                    end else begin
                        w = exp_q.pop_front();
                        check("rnd_data", out_data, w.data);
                        check("rnd_len", 32'(out_len), 32'(w.len));
                        check("rnd_last", 32'(out_last), 32'(w.last));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_len   = out_len;
                prev_last  = out_last;
            end
            check("rnd_beats_consumed", 32'(idx), 32'(beats.size()));
            check("rnd_words_left", 32'(exp_q.size()), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
